// File: rtl/modexp_host_sequencer_if.sv
// rtl/modexp_host_sequencer_if.sv - operand/result streams and ModExp control pins
`timescale 1ns/1ps
interface modexp_host_sequencer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  me_startInput;
    logic [DATA_WIDTH-1:0] me_inp;
    logic                  me_startCompute;
    logic                  me_getResult;
    logic [4:0]            me_state;
    logic [DATA_WIDTH-1:0] me_outp;

    modport master (
        input  in_valid, in_data, in_last, out_ready, me_state, me_outp,
        output in_ready, out_valid, out_data, out_last,
               me_startInput, me_inp, me_startCompute, me_getResult
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready, me_state, me_outp,
        input  in_ready, out_valid, out_data, out_last,
               me_startInput, me_inp, me_startCompute, me_getResult
    );
endinterface

// File: rtl/modexp_host_sequencer.sv
// rtl/modexp_host_sequencer.sv - buffers an operand frame, replays it to ModExp, drains the result
`timescale 1ns/1ps
module modexp_host_sequencer #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          NUM_WORDS      = 64,
    parameter int          GAP_CYCLES     = 2,
    parameter logic [4:0]  DONE_STATE     = 5'd0,
    parameter int          RESULT_LAT     = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    modexp_host_sequencer_if.master bus,
    output logic                   busy,
    output logic                   err_frame,
    output logic                   err_timeout
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] WORDS    = IW'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE, FILL, START, STREAM, GAP, COMPUTE, RESULT, DRAIN
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [IW-1:0]         idx;
    logic [31:0]           cnt;
    logic                  armed;
    logic                  accept;
    logic                  at_last;
    logic                  capture;
    logic                  done_seen;
    logic                  timed_out;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] me_inp_q;

    assign accept    = bus.in_valid & bus.in_ready;
    assign at_last   = (idx == LAST_IDX);
    assign capture   = (cnt >= 32'(RESULT_LAT));
    assign done_seen = armed && (bus.me_state == DONE_STATE);
    assign timed_out = (cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = FILL;
            FILL: begin
                if (accept) begin
                    if (at_last)          state_next = START;
                    else if (bus.in_last) state_next = IDLE;
                end
            end
            START:   state_next = STREAM;
            STREAM:  if (idx == WORDS) state_next = (GAP_CYCLES == 0) ? COMPUTE : GAP;
            GAP:     if (cnt == 32'(GAP_CYCLES - 1)) state_next = COMPUTE;
            COMPUTE: begin
                if (done_seen)      state_next = RESULT;
                else if (timed_out) state_next = IDLE;
            end
            RESULT:  if (capture && at_last) state_next = DRAIN;
            DRAIN:   if (bus.out_ready && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready        = (state == IDLE) || (state == FILL);
        bus.me_startInput   = (state == START);
        bus.me_startCompute = (state == COMPUTE) || (state == RESULT);
        bus.me_getResult    = (state == RESULT);
        bus.out_valid       = (state == DRAIN);
        bus.out_last        = (state == DRAIN) && at_last;
        bus.out_data        = (state == DRAIN) ? mem[idx[AW-1:0]] : '0;
        bus.me_inp          = me_inp_q;
        busy                = (state != IDLE);
    end

    // One write port shared by operand fill and result capture; results overwrite operands.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx[AW-1:0];
        mem_wdata = bus.in_data;
        case (state)
            IDLE: begin
                mem_we    = accept;
                mem_waddr = '0;
            end
            FILL:    mem_we = accept;
            RESULT: begin
                mem_we    = capture;
                mem_wdata = bus.me_outp;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        err_frame   <= 1'b0;
        err_timeout <= 1'b0;
        if (!reset) begin
            idx      <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            me_inp_q <= '0;
        end else begin
            cnt   <= (state_next != state) ? 32'd0 : cnt + 32'd1;
            // Arm only after ModExp has left DONE_STATE, so a stale idle value is not taken as completion.
            armed <= (state == COMPUTE) && (armed || (bus.me_state != DONE_STATE));
            case (state)
                IDLE: if (accept) idx <= IW'(1);
                FILL: begin
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (at_last) begin
                            err_frame <= ~bus.in_last;
                        end else if (bus.in_last) begin
                            err_frame <= 1'b1;
                            idx       <= '0;
                        end
                    end
                end
                START: begin
                    me_inp_q <= mem[0];
                    idx      <= IW'(1);
                end
                // idx runs one ahead of the word on me_inp so the stream has no bubble.
                STREAM: begin
                    if (idx != WORDS) begin
                        me_inp_q <= mem[idx[AW-1:0]];
                        idx      <= idx + 1'b1;
                    end else begin
                        idx <= '0;
                    end
                end
                COMPUTE: if (!done_seen && timed_out) err_timeout <= 1'b1;
                RESULT:  if (capture) idx <= at_last ? '0 : idx + 1'b1;
                DRAIN:   if (bus.out_ready) idx <= at_last ? '0 : idx + 1'b1;
                default: idx <= idx;
            endcase
        end
    end
endmodule
